regfile_spi_tx: RTL and testbench
=================================

// Module: regfile_spi_tx
// PURPOSE
// - Host-to-sensor side of the register path. The host writes the 7-bit register file
//   through trigger-in commands; this block reads a range of that register file back and
//   serialises each entry to the SPI sensor as a write frame.
// - Sits between the register-file read port and the sensor SPI pins. Started by a
//   trigger-in pulse; busy/done/rx status is returned on wire-out.
// - Sampled MISO is captured per frame, so the sensor's echo/status byte is readable by the host.
// PARAMETERS
// - ADDR_W   7  register-file address width; also the address field width in the frame
// - DATA_W   7  register data width; also the data field width in the frame
// - CLK_DIV  4  SCLK half-period in clk cycles (>=1); SCLK = clk/(2*CLK_DIV)
// - CS_GAP   4  clk cycles cs_n stays high between consecutive frames (>=1)
// PORTS
// - clk         in   1          system clock
// - reset_n     in   1          asynchronous, active-low reset
// - start       in   1          1-clk pulse: begin burst (ignored while busy)
// - start_addr  in   ADDR_W     first register address of burst
// - count       in   ADDR_W+1   number of frames, 0..2**ADDR_W
// - rd_addr     out  ADDR_W     register-file read address
// - rd_data     in   DATA_W     register-file read data, valid 1 clk after rd_addr
// - sclk        out  1          SPI clock, mode 0 (idle low)
// - cs_n        out  1          SPI chip select, active low
// - mosi        out  1          SPI data out, MSB first
// - miso        in   1          SPI data in
// - busy        out  1          high from accepted start until done
// - done        out  1          1-clk pulse at burst completion
// - frames_sent out  ADDR_W+1   frames completed in current/last burst
// - rx_last     out  8          low 8 bits shifted in during the last completed frame
// BEHAVIOUR
// - Reset: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rd_addr=0, frames_sent=0, rx_last=0, FSM=IDLE.
// - Frame = {1'b0 (write flag), addr[ADDR_W-1:0], 1'b0, data[DATA_W-1:0]}, FW=ADDR_W+DATA_W+2 (16 by default).
// - FSM states and transitions:
//   - IDLE: on start, latch start_addr/count, set busy, clear frames_sent.
//     count==0 goes to DONE; otherwise goes to FETCH.
//   - FETCH (1 clk): drive rd_addr = current address.
//   - LOAD (1 clk): capture rd_data into the shift register; drive cs_n=0 and mosi=frame MSB.
//   - SHIFT: SCLK toggles every CLK_DIV clks.
//     MISO is sampled on the rising edge; MOSI advances on the falling edge.
//     After the FW-th falling edge: cs_n=1, mosi=0, rx_last=rx_shift[7:0], frames_sent++.
//     cs_n is low for exactly 2*FW*CLK_DIV clks (128 by default).
//   - GAP (CS_GAP clks): then DONE if frames_sent==count_latched, else address+1 and FETCH.
//   - DONE (1 clk): done=1, busy=0; return to IDLE.
// - Address increments modulo 2**ADDR_W (127 -> 0 wrap).
// - start while busy is ignored; latched values are not disturbed.
// - start in the DONE cycle is also ignored; a start in the following IDLE cycle is accepted.
// - Reset mid-frame: outputs return to reset values immediately (asynchronous). No partial frame resumes.
// - Frame-to-frame period = 2 + 2*FW*CLK_DIV + CS_GAP clks. Start to cs_n fall = 2 clks (FETCH, LOAD).
// - All counters are sized so that count=2**ADDR_W completes without overflow.
// STRUCTURE
// - Shared package/header (params.vh):
//   - FSM state encodings IDLE/FETCH/LOAD/SHIFT/GAP/DONE
//   - SPI write-flag constant
//   - frame-width macro
// - Natural sub-module: spi_shift_engine.
//   - Owns the SCLK divider, TX/RX shift registers and bit counter.
//   - Interface: load/frame_in -> frame_done/rx_word.
//   - The FSM and address sequencing stay in regfile_spi_tx.
// TESTING
// - reg[1]=1, start_addr=1, count=1 -> one frame, MOSI=0x0101, cs_n low 128 clks, done 1 clk, frames_sent=1.
// - reg[127]=42, reg[0]=5, start_addr=127, count=2 -> frames 0x7F2A then 0x0005 (wrap); CS_GAP=4 high clks between.
// - count=0 -> no cs_n activity; busy high 1 clk; done pulses; frames_sent=0.
// - Second start 10 clks into a 3-frame burst -> ignored; exactly 3 frames sent, single done pulse.
// - miso tied to mosi, reg[5]=0x2A, start_addr=5, count=1 -> rx_last=0x2A.
// - reset_n low mid-SHIFT of frame 1 -> cs_n=1, sclk=0, busy=0 at once. After release, a new start gives a full clean frame.

Source files
------------

// File: rtl/regfile_spi_tx_pkg.sv
// rtl/regfile_spi_tx_pkg.sv - shared types and constants for the register-file SPI transmitter
//
// Purpose: FSM state encoding, SPI write-flag value and frame-width helper used by
//          regfile_spi_tx and its shift engine.
// Ports:   none (package).
package regfile_spi_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Leading bit of every frame; 0 marks a register write to the sensor.
  localparam logic SPI_WR_FLAG = 1'b0;

  // {write flag, address, separator bit, data}
  function automatic int frame_width(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

// File: rtl/regfile_spi_tx_shift_engine.sv
// rtl/regfile_spi_tx_shift_engine.sv - SPI mode-0 frame serialiser with SCLK divider
//
// Purpose: shifts one FW-bit frame out MSB first, samples MISO on rising SCLK,
//          raises cs_n again on the FW-th falling edge.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   load, frame_in    1-clk request to start a frame with the given word
//   miso              SPI data in
//   sclk, cs_n, mosi  SPI pins (registered)
//   frame_done        1-clk strobe coincident with the edge that ends the frame
//   rx_word           last 8 bits sampled from MISO
module regfile_spi_tx_shift_engine
  import regfile_spi_tx_pkg::*;
#(
  parameter int FW      = 16,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [FW-1:0] frame_in,
  input  logic          miso,
  output logic          sclk,
  output logic          cs_n,
  output logic          mosi,
  output logic          frame_done,
  output logic [7:0]    rx_word
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FW);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [FW-1:0]    tx_shift;
  logic [7:0]       rx_shift;
  logic             tick;

  assign tick = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Combinational so the owning FSM updates its status on the same edge cs_n rises.
  assign frame_done = tick && sclk && (bit_cnt == BIT_W'(FW - 1));
  assign rx_word    = rx_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else if (load) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= frame_in;
      sclk     <= 1'b0;
      cs_n     <= 1'b0;
      mosi     <= frame_in[FW-1];
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk     <= 1'b1;
          rx_shift <= {rx_shift[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (frame_done) begin
            active <= 1'b0;
            cs_n   <= 1'b1;
            mosi   <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + BIT_W'(1);
            tx_shift <= tx_shift << 1;
            mosi     <= tx_shift[FW-2];
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_spi_tx.sv
// rtl/regfile_spi_tx.sv - reads a register-file range and writes each entry to an SPI sensor
//
// Purpose: burst sequencer; fetches count registers from start_addr (wrapping) and sends
//          each as a write frame through the shift engine, reporting progress and MISO echo.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  1-clk burst request (ignored unless idle)
//   start_addr, count      first address and number of frames (0..2**ADDR_W)
//   rd_addr, rd_data       register-file read port (data valid 1 clk after address)
//   sclk, cs_n, mosi, miso SPI mode-0 pins
//   busy, done             burst status; done is a 1-clk pulse
//   frames_sent, rx_last   frames completed so far, low byte received in last frame
module regfile_spi_tx
  import regfile_spi_tx_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 7,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   frames_sent,
  output logic [7:0]        rx_last
);

  localparam int FW    = frame_width(ADDR_W, DATA_W);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [ADDR_W:0] FS_ONE = 1;

  state_t            state;
  logic [ADDR_W:0]   count_l;
  logic [GAP_W-1:0]  gap_cnt;
  logic              load;
  logic [FW-1:0]     frame;
  logic              frame_done;
  logic [7:0]        rx_word;

  // rd_addr doubles as the current burst address; rd_data for it arrives during LOAD.
  assign load  = (state == ST_LOAD);
  assign frame = {SPI_WR_FLAG, rd_addr, 1'b0, rd_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      count_l     <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      rx_last     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr     <= start_addr;
            count_l     <= count;
            frames_sent <= '0;
            busy        <= 1'b1;
            if (count == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD:  state <= ST_SHIFT;
        ST_SHIFT: begin
          if (frame_done) begin
            frames_sent <= frames_sent + FS_ONE;
            rx_last     <= rx_word;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
            if (frames_sent == count_l) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= ST_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          // A start arriving here is deliberately dropped; IDLE accepts the next one.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  regfile_spi_tx_shift_engine #(
    .FW      (FW),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .frame_in   (frame),
    .miso       (miso),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .frame_done (frame_done),
    .rx_word    (rx_word)
  );

endmodule

// File: tb/tb_regfile_spi_tx.sv
// tb/tb_regfile_spi_tx.sv - self-checking bench for regfile_spi_tx against a frame-level model
module tb_regfile_spi_tx;

  localparam int AW = 7;
  localparam int DW = 7;
  localparam int CD = 4;
  localparam int CG = 4;
  localparam int LOW_CLKS = 2 * 16 * CD;          // cs_n low time per frame
  localparam int PERIOD   = 2 + LOW_CLKS + CG;    // frame-to-frame period
  localparam int HIGH_CLKS = PERIOD - LOW_CLKS;   // GAP + FETCH + LOAD

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          sclk, cs_n, mosi, miso;
  logic          busy, done;
  logic [AW:0]   frames_sent;
  logic [7:0]    rx_last;
  logic          inv = 1'b0;

  logic [DW-1:0] regs [128];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_rx = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= regs[rd_addr];
  assign miso = mosi ^ inv;

  regfile_spi_tx #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(CD), .CS_GAP(CG)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent),
    .rx_last     (rx_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pin monitor: decodes SPI frames sampled on clk falling edges.
  int fall_q[$];
  int rise_q[$];
  int nb_q[$];
  logic [15:0] frm_q[$];
  logic [15:0] cap = '0;
  int nbits = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int mon_err = 0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      nbits     = 0;
    end else begin
      if (prev_cs && !cs_n) begin
        fall_q.push_back(cyc);
        nbits = 0;
        cap = '0;
        if (sclk) mon_err++;
      end
      if (!prev_sclk && sclk) begin
        if (cs_n) mon_err++;
        cap = {cap[14:0], mosi};
        nbits++;
      end
      if (!prev_cs && cs_n) begin
        rise_q.push_back(cyc);
        frm_q.push_back(cap);
        nb_q.push_back(nbits);
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  task automatic run_burst(input int sa, input int cnt, input bit dbl, input bit dstart);
    int c0;
    int k;
    int a;
    int nf;
    bit saw;
    logic [15:0] ef;
    fall_q.delete();
    rise_q.delete();
    frm_q.delete();
    nb_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    mon_err  = 0;
    @(posedge clk); #1;
    start_addr = AW'(sa);
    count      = 8'(cnt);
    start      = 1'b1;
    c0         = cyc + 1;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = AW'($urandom);
    count      = 8'($urandom);
    if (dbl) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    saw = 1'b0;
    k = 0;
    while (!saw && k < cnt * 140 + 50) begin
      @(negedge clk);
      k++;
      if (done) saw = 1'b1;
    end
    check("done_seen", 32'(saw), 32'd1);
    if (dstart) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    repeat (8) @(negedge clk);

    nf = frm_q.size();
    check("frame_count", 32'(nf), 32'(cnt));
    check("cs_fall_count", 32'(fall_q.size()), 32'(cnt));
    for (int i = 0; i < nf && i < cnt; i++) begin
      a  = (sa + i) % 128;
      ef = {1'b0, 7'(a), 1'b0, regs[a]};
      check("frame_data", 32'(frm_q[i]), 32'(ef));
      check("frame_bits", 32'(nb_q[i]), 32'd16);
      check("cs_low_clks", 32'(rise_q[i] - fall_q[i]), 32'(LOW_CLKS));
      if (i > 0) check("cs_high_clks", 32'(fall_q[i] - rise_q[i-1]), 32'(HIGH_CLKS));
    end
    if (nf > 0) check("start_to_cs", 32'(fall_q[0] - c0), 32'd2);
    if (cnt > 0) begin
      a = (sa + cnt - 1) % 128;
      exp_rx = {1'b0, regs[a]} ^ {8{inv}};
    end
    check("frames_sent", 32'(frames_sent), 32'(cnt));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_clks", 32'(busy_cnt), 32'(cnt * PERIOD + 1));
    check("busy_after", 32'(busy), 32'd0);
    check("sclk_outside_cs", 32'(mon_err), 32'd0);
    check("rx_last", 32'(rx_last), 32'(exp_rx));
  endtask

  initial begin
    int k;
    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    for (int i = 0; i < 128; i++) regs[i] = DW'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    check("rst_rx_last", 32'(rx_last), 32'd0);
    reset_n = 1'b1;

    regs[1] = 7'd1;
    run_burst(1, 1, 1'b0, 1'b0);
    regs[127] = 7'd42;
    regs[0]   = 7'd5;
    run_burst(127, 2, 1'b0, 1'b0);
    run_burst($urandom_range(0, 127), 0, 1'b0, 1'b0);
    run_burst(20, 3, 1'b1, 1'b0);
    run_burst(30, 1, 1'b0, 1'b1);
    regs[5] = 7'h2A;
    run_burst(5, 1, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      inv = 1'($urandom);
      run_burst($urandom_range(0, 127), $urandom_range(1, 4), 1'b0, 1'b0);
    end
    inv = 1'b1;
    run_burst($urandom_range(0, 127), 128, 1'b0, 1'b0);
    inv = 1'b0;

    // Reset in the middle of the first frame of a burst.
    @(posedge clk); #1;
    start_addr = 7'd9;
    count      = 8'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (cs_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    check("pre_reset_cs_low", 32'(cs_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    check("mid_rst_frames_sent", 32'(frames_sent), 32'd0);
    check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    exp_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    run_burst($urandom_range(0, 127), 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
